// File: rtl/wm_pkg.sv
// -----------------------------------------------------------------------------
// wm_pkg
// Shared types and constants for the washing-machine plant model.
//   - door_state_e : door FSM encoding (OPEN / CLOSED / LOCKED)
//   - FLT_*        : fault-code values reported on fault_code
//   - LEVEL_W / SPEED_W / FAULT_W : feedback bus widths
// -----------------------------------------------------------------------------
package wm_pkg;

    localparam int unsigned LEVEL_W = 5;
    localparam int unsigned SPEED_W = 4;
    localparam int unsigned FAULT_W = 3;

    typedef enum logic [1:0] {
        DOOR_OPEN   = 2'd0,
        DOOR_CLOSED = 2'd1,
        DOOR_LOCKED = 2'd2
    } door_state_e;

    localparam logic [FAULT_W-1:0] FLT_NONE          = 3'd0;
    localparam logic [FAULT_W-1:0] FLT_FILL_DRAIN    = 3'd1;
    localparam logic [FAULT_W-1:0] FLT_SPIN_UNLOCKED = 3'd2;
    localparam logic [FAULT_W-1:0] FLT_FILL_OPEN     = 3'd3;
    localparam logic [FAULT_W-1:0] FLT_LOCK_OPEN     = 3'd4;
    localparam logic [FAULT_W-1:0] FLT_OVERFLOW      = 3'd5;

endpackage

// File: rtl/wm_rate_div.sv
// -----------------------------------------------------------------------------
// wm_rate_div
// Prescaler producing a one-cycle tick every DIV enabled cycles.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   en_i    : count enable
//   clr_i   : synchronous clear (dominates en_i)
//   tick_o  : high in the cycle the count reaches DIV-1 while enabled
// The counter returns to 0 on tick, on clear, and whenever disabled, so a
// fresh enable always needs DIV full cycles before its first tick.
// -----------------------------------------------------------------------------
module wm_rate_div #(
    parameter int unsigned DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && !clr_i && (cnt_q == CNT_W'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wm_plant_model.sv
// -----------------------------------------------------------------------------
// wm_plant_model
// Plant/sensor emulator for the washing-machine controller actuator interface.
// Inputs : clk, rst (async active-low), fill_valve, drain_valve, motor_on,
//          door_lock, door_close_req, door_open_req
// Outputs: door_close, water_full, water_empty, level[4:0], drum_speed[3:0],
//          fault (sticky), fault_code[2:0] (first recorded cause)
// Build option: define WM_PLANT_OVERFLOW_EN to report fault code 5 when
// fill_valve is held FILL_DIV consecutive cycles at a full tank.
// All outputs are registers or decodes of registers.
// -----------------------------------------------------------------------------
module wm_plant_model
    import wm_pkg::*;
#(
    parameter int unsigned LEVEL_MAX = 15,
    parameter int unsigned FILL_DIV  = 4,
    parameter int unsigned DRAIN_DIV = 2,
    parameter int unsigned SPEED_MAX = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fill_valve,
    input  logic               drain_valve,
    input  logic               motor_on,
    input  logic               door_lock,
    input  logic               door_close_req,
    input  logic               door_open_req,
    output logic               door_close,
    output logic               water_full,
    output logic               water_empty,
    output logic [LEVEL_W-1:0] level,
    output logic [SPEED_W-1:0] drum_speed,
    output logic               fault,
    output logic [FAULT_W-1:0] fault_code
);

    localparam logic [LEVEL_W-1:0] LVL_MAX = LEVEL_W'(LEVEL_MAX);
    localparam logic [SPEED_W-1:0] SPD_MAX = SPEED_W'(SPEED_MAX);

    door_state_e        door_q, door_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic               fault_q, fault_d;
    logic [FAULT_W-1:0] code_q, code_d;
    logic [FAULT_W-1:0] cause;
    logic               fill_only, drain_only;
    logic               fill_tick, drain_tick;

    assign fill_only  = fill_valve && !drain_valve;
    assign drain_only = drain_valve && !fill_valve;

    // Each prescaler is cleared whenever its own direction is not the sole
    // active one, which covers idle, both-valves and direction changes.
    wm_rate_div #(.DIV(FILL_DIV)) u_fill_div (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (fill_valve),
        .clr_i  (!fill_only),
        .tick_o (fill_tick)
    );

    wm_rate_div #(.DIV(DRAIN_DIV)) u_drain_div (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (drain_valve),
        .clr_i  (!drain_only),
        .tick_o (drain_tick)
    );

`ifdef WM_PLANT_OVERFLOW_EN
    logic [4:0] ovf_cnt_q, ovf_cnt_d;
    logic       ovf_cond, ovf_hit;

    assign ovf_cond = fill_valve && (level_q == LVL_MAX);
    // Fires on the FILL_DIV-th consecutive cycle of filling a full tank.
    assign ovf_hit  = ovf_cond && (32'(ovf_cnt_q) >= FILL_DIV - 1);

    always_comb begin
        ovf_cnt_d = '0;
        if (ovf_cond) begin
            ovf_cnt_d = (32'(ovf_cnt_q) >= FILL_DIV) ? ovf_cnt_q : ovf_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end
`endif

    always_comb begin
        door_d = door_q;
        unique case (door_q)
            DOOR_OPEN:   if (door_close_req) door_d = DOOR_CLOSED;
            DOOR_CLOSED: begin
                if (door_open_req)  door_d = DOOR_OPEN;
                else if (door_lock) door_d = DOOR_LOCKED;
            end
            DOOR_LOCKED: if (!door_lock) door_d = DOOR_CLOSED;
            default:     door_d = DOOR_OPEN;
        endcase
    end

    always_comb begin
        level_d = level_q;
        if (fill_tick && level_q != LVL_MAX) begin
            level_d = level_q + 1'b1;
        end else if (drain_tick && level_q != '0) begin
            level_d = level_q - 1'b1;
        end

        speed_d = speed_q;
        if (motor_on && door_q == DOOR_LOCKED) begin
            if (speed_q != SPD_MAX) speed_d = speed_q + 1'b1;
        end else if (speed_q != '0) begin
            speed_d = speed_q - 1'b1;
        end
    end

    always_comb begin
        cause = FLT_NONE;
        if (fill_valve && drain_valve)                  cause = FLT_FILL_DRAIN;
        else if (motor_on && door_q != DOOR_LOCKED)     cause = FLT_SPIN_UNLOCKED;
        else if (fill_valve && door_q == DOOR_OPEN)     cause = FLT_FILL_OPEN;
        else if (door_lock && door_q == DOOR_OPEN)      cause = FLT_LOCK_OPEN;
`ifdef WM_PLANT_OVERFLOW_EN
        else if (ovf_hit)                               cause = FLT_OVERFLOW;
`endif

        fault_d = fault_q;
        code_d  = code_q;
        if (!fault_q && cause != FLT_NONE) begin
            fault_d = 1'b1;
            code_d  = cause;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            door_q  <= DOOR_OPEN;
            level_q <= '0;
            speed_q <= '0;
            fault_q <= 1'b0;
            code_q  <= FLT_NONE;
        end else begin
            door_q  <= door_d;
            level_q <= level_d;
            speed_q <= speed_d;
            fault_q <= fault_d;
            code_q  <= code_d;
        end
    end

    assign door_close  = (door_q != DOOR_OPEN);
    assign water_full  = (level_q == LVL_MAX);
    assign water_empty = (level_q == '0);
    assign level       = level_q;
    assign drum_speed  = speed_q;
    assign fault       = fault_q;
    assign fault_code  = code_q;

endmodule

// File: tb/tb_wm_plant_model.sv
module tb_wm_plant_model;

    logic       clk = 1'b0;
    logic       rst;
    logic       fill_valve, drain_valve, motor_on, door_lock;
    logic       door_close_req, door_open_req;
    logic       door_close, water_full, water_empty, fault;
    logic [4:0] level;
    logic [3:0] drum_speed;
    logic [2:0] fault_code;

    int checks   = 0;
    int failures = 0;

    wm_plant_model #(
        .LEVEL_MAX (15),
        .FILL_DIV  (4),
        .DRAIN_DIV (2),
        .SPEED_MAX (15)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fill_valve     (fill_valve),
        .drain_valve    (drain_valve),
        .motor_on       (motor_on),
        .door_lock      (door_lock),
        .door_close_req (door_close_req),
        .door_open_req  (door_open_req),
        .door_close     (door_close),
        .water_full     (water_full),
        .water_empty    (water_empty),
        .level          (level),
        .drum_speed     (drum_speed),
        .fault          (fault),
        .fault_code     (fault_code)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        step(1);
    endtask

    initial begin
        rst = 1'b0;
        fill_valve = 0; drain_valve = 0; motor_on = 0; door_lock = 0;
        door_close_req = 0; door_open_req = 0;
        step(2);

        // Reset state
        chk("rst_door_close", 32'(door_close), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_empty", 32'(water_empty), 1);
        chk("rst_full", 32'(water_full), 0);
        chk("rst_speed", 32'(drum_speed), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_code", 32'(fault_code), 0);
        rst = 1'b1;
        step(1);

        // Door close, lock, open request ignored while locked
        door_close_req = 1; step(1); door_close_req = 0;
        chk("door_closed", 32'(door_close), 1);
        door_lock = 1; step(1);
        door_open_req = 1; step(2); door_open_req = 0;
        chk("locked_ignores_open", 32'(door_close), 1);
        chk("locked_no_fault", 32'(fault), 0);

        // Fill: first step after 4 cycles, full after 60
        fill_valve = 1;
        step(3);  chk("fill_c3", 32'(level), 0);
        step(1);  chk("fill_c4", 32'(level), 1);
        step(52); chk("fill_c56", 32'(level), 14);
        chk("fill_c56_notfull", 32'(water_full), 0);
        step(4);  chk("fill_c60", 32'(level), 15);
        chk("fill_c60_full", 32'(water_full), 1);
        step(3);  chk("fill_c63_nofault", 32'(fault), 0);
        step(1);
`ifdef WM_PLANT_OVERFLOW_EN
        chk("overflow_fault", 32'(fault), 1);
        chk("overflow_code", 32'(fault_code), 5);
`else
        chk("no_overflow_fault", 32'(fault), 0);
`endif
        step(6);  chk("fill_saturate", 32'(level), 15);

        // Drain: 2 cycles per step, empty after 30
        fill_valve = 0; drain_valve = 1;
        step(1);  chk("drain_c1", 32'(level), 15);
        step(1);  chk("drain_c2", 32'(level), 14);
        step(27); chk("drain_c29", 32'(level), 1);
        chk("drain_c29_notempty", 32'(water_empty), 0);
        step(1);  chk("drain_c30_empty", 32'(water_empty), 1);
        step(4);  chk("drain_saturate", 32'(level), 0);
        drain_valve = 0;

        // Drum spin-up and spin-down while locked
        motor_on = 1;
        step(14); chk("spin_c14", 32'(drum_speed), 14);
        step(1);  chk("spin_c15", 32'(drum_speed), 15);
        step(5);  chk("spin_sat", 32'(drum_speed), 15);
        motor_on = 0;
        step(14); chk("spindown_c14", 32'(drum_speed), 1);
        step(1);  chk("spindown_c15", 32'(drum_speed), 0);
`ifndef WM_PLANT_OVERFLOW_EN
        chk("locked_ops_no_fault", 32'(fault), 0);
`endif

        // Asynchronous reset mid-fill at level 7
        fill_valve = 1;
        step(28); chk("midfill_level", 32'(level), 7);
        rst = 1'b0;
        #1;
        chk("async_rst_level", 32'(level), 0);
        chk("async_rst_door", 32'(door_close), 0);
        chk("async_rst_fault", 32'(fault), 0);
        fill_valve = 0; door_lock = 0;
        step(1);
        rst = 1'b1;
        step(1);

        // Door open: fill+drain+lock -> code 1, sticky against motor_on
        fill_valve = 1; drain_valve = 1; door_lock = 1;
        step(1);
        fill_valve = 0; drain_valve = 0; door_lock = 0;
        chk("flt1_fault", 32'(fault), 1);
        chk("flt1_code", 32'(fault_code), 1);
        motor_on = 1; step(1); motor_on = 0;
        chk("flt1_sticky", 32'(fault_code), 1);

        // Motor while open beats lock-while-open -> code 2
        reset_pulse();
        motor_on = 1; door_lock = 1; step(1); motor_on = 0; door_lock = 0;
        chk("flt2_code", 32'(fault_code), 2);

        // Fill while open -> code 3
        reset_pulse();
        fill_valve = 1; step(1); fill_valve = 0;
        chk("flt3_code", 32'(fault_code), 3);

        // Lock while open -> code 4
        reset_pulse();
        chk("postrst_nofault", 32'(fault), 0);
        door_lock = 1; step(1); door_lock = 0;
        chk("flt4_code", 32'(fault_code), 4);

        // Both door requests while closed: open wins
        reset_pulse();
        door_close_req = 1; step(1);
        chk("req_closed", 32'(door_close), 1);
        door_open_req = 1; step(1);
        door_close_req = 0; door_open_req = 0;
        chk("open_wins", 32'(door_close), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wm_plant_model.md
# wm_plant_model

Synthesizable plant/sensor emulator forming the far end of the washing-machine controller's actuator interface. It consumes the controller's fill_valve, drain_valve, motor_on and door_lock commands and returns door_close, water-level and drum-speed feedback, with a sticky interlock-fault monitor. It closes the loop for controller regression and for FPGA demo builds in place of real hardware.

## Interface
- LEVEL_MAX, 15: full-tank level; level width is 5 bits.
- FILL_DIV, 4: cycles of fill per level step up, 1..16.
- DRAIN_DIV, 2: cycles of drain per level step down, 1..16.
- SPEED_MAX, 15: drum speed ceiling; speed width is 4 bits.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- fill_valve / drain_valve / motor_on / door_lock  in  1 each  controller commands.
- door_close_req / door_open_req  in  1 each  user door actions, level-sampled.
- door_close  out  1  door physically shut (CLOSED or LOCKED).
- water_full / water_empty  out  1 each  level==LEVEL_MAX / level==0.
- level  out  5  current water level.
- drum_speed  out  4  current drum speed.
- fault  out  1  sticky interlock violation.
- fault_code  out  3  first recorded fault cause (0 = none).

## Operation
- Door FSM, states OPEN, CLOSED, LOCKED:
  - OPEN->CLOSED on door_close_req.
  - CLOSED->OPEN on door_open_req. If both requests are high, open wins.
  - CLOSED->LOCKED when door_lock=1.
  - LOCKED->CLOSED when door_lock=0.
  - door_open_req is ignored in LOCKED.
- Level, fill-only (fill_valve & !drain_valve):
  - Prescaler counts up each cycle.
  - At count FILL_DIV-1, level increments, saturating at LEVEL_MAX, and the prescaler clears.
- Level, drain-only: same mechanism with DRAIN_DIV, level decrements and saturates at 0.
- Level, idle or both valves high: level holds and the prescaler clears. The prescaler also clears whenever the active direction changes.
- Drum speed:
  - If motor_on and door is LOCKED: +1 per cycle up to SPEED_MAX.
  - Otherwise: -1 per cycle down to 0.
- Faults are checked every cycle; the lowest-numbered active cause wins:
  - 1: fill_valve & drain_valve.
  - 2: motor_on while door is not LOCKED.
  - 3: fill_valve while door is OPEN.
  - 4: door_lock while door is OPEN.
- fault and fault_code latch on the first violation and hold until reset. Later violations do not overwrite the code.

## Timing
- Reset values:
  - door FSM = OPEN, so door_close=0.
  - level=0, water_empty=1, water_full=0.
  - drum_speed=0.
  - prescaler=0.
  - fault=0, fault_code=0.
- All outputs are registered or decoded from registers; there is no combinational input-to-output path.
- Door: a request sampled at edge N changes door_close after edge N.
- Level: fill first sampled at edge N updates level after edge N+FILL_DIV-1. Full tank from empty takes LEVEL_MAX*FILL_DIV cycles.
- Fault: a violation sampled at edge N asserts fault after edge N.
- Reset mid-operation: all state returns immediately (asynchronously) to reset values, including the door returning to OPEN.

## Configuration
- WM_PLANT_OVERFLOW_EN defined: fill_valve held for FILL_DIV consecutive cycles at level==LEVEL_MAX raises fault code 5 (overflow), subject to the normal priority and sticky rules.
- WM_PLANT_OVERFLOW_EN undefined: level silently saturates at LEVEL_MAX and code 5 is never produced.

## Structure
- Package wm_pkg holds:
  - door-state enum (DOOR_OPEN, DOOR_CLOSED, DOOR_LOCKED);
  - fault-code constants (FLT_NONE, FLT_FILL_DRAIN, FLT_SPIN_UNLOCKED, FLT_FILL_OPEN, FLT_LOCK_OPEN, FLT_OVERFLOW);
  - level and speed width constants.
- One sub-module, wm_rate_div: a parameterized prescaler with enable and clear inputs and a one-cycle tick output. It is instantiated twice, once for fill and once for drain.

## Test plan
- Reset, then door_close_req=1 for 1 cycle -> door_close=1 the next cycle; then door_lock=1 -> LOCKED; then door_open_req=1 -> door_close stays 1 and fault=0.
- Locked door, fill_valve=1 for 60 cycles with FILL_DIV=4 -> level steps every 4 cycles, water_full=1 at cycle 60, level stays 15 afterwards; then drain_valve only for 30 cycles -> water_empty=1 at cycle 30.
- Locked door, motor_on=1 for 20 cycles -> drum_speed reaches 15 after 15 cycles; motor_on=0 -> drum_speed reaches 0 after 15 cycles.
- Door OPEN, assert fill_valve, drain_valve and door_lock together -> fault=1, fault_code=1 next cycle; a later motor_on leaves fault_code=1.
- Mid-fill at level 7 (LOCKED), pulse rst low -> level=0, door_close=0, fault=0 immediately.
- With WM_PLANT_OVERFLOW_EN defined, fill to 15 and hold fill 4 more cycles -> fault_code=5; without the macro, fault stays 0.
